ldm_stm_sequencer: RTL

Multi-register transfer sequencer for LDM/STM-class instructions. Sits directly upstream of the register file. It walks a 16-bit register list and, one register at a time, drives the 4-bit register-select field, a one-cycle load strobe and the write data into the register file. It also drives the memory address/request handshake and computes the base-register writeback value. The control unit hands it one instruction via a START pulse and waits for DONE.

---
 rtl/ldm_stm_sequencer.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/ldm_stm_sequencer.sv
// Walks a 16-bit register list one memory access at a time, feeding loads and the base writeback to the RF.
// Zero-wait: 1 cycle/register on stores, 2 on loads; MEM_DONE low holds REQ with all outputs frozen.
module ldm_stm_sequencer (
  input  logic        Clk,
  input  logic        RESET,
  input  logic        START,
  input  logic [15:0] REGLIST,
  input  logic [31:0] BASE,
  input  logic        UP,
  input  logic        PRE,
  input  logic        LDOP,
  input  logic        WBEN,
  input  logic [3:0]  BASE_SEL,
  input  logic        MEM_DONE,
  input  logic [31:0] MEM_RDATA,
  output logic        MEM_REQ,
  output logic        MEM_RW,
  output logic [31:0] ADDR,
  output logic [3:0]  REG_SEL,
  output logic        RF_LOAD,
  output logic [31:0] RF_DATA,
  output logic        BUSY,
  output logic        DONE
);

  typedef enum logic [2:0] {IDLE, SETUP, REQ, WRITE, WBACK, FIN} state_t;

  state_t      state;
  logic [15:0] regList;
  logic [15:0] mask;
  logic [31:0] base;
  logic [31:0] wbVal;
  logic        up;
  logic        pre;
  logic        wbEn;
  logic [3:0]  baseSel;

  logic [31:0] xferBytes;
  logic [31:0] startAddr;
  logic [31:0] wbCalc;
  logic [31:0] nextAddr;
  logic [15:0] maskNext;
  logic        skipWb;

  function automatic logic [4:0] popCount(input logic [15:0] m);
    logic [4:0] cnt;
    cnt = 5'd0;
    for (int i = 0; i < 16; i++) cnt = cnt + {4'd0, m[i]};
    return cnt;
  endfunction

  function automatic logic [3:0] lowestSet(input logic [15:0] m);
    logic [3:0] idx;
    idx = 4'd0;
    for (int i = 15; i >= 0; i--) if (m[i]) idx = i[3:0];
    return idx;
  endfunction

  always_comb begin
    xferBytes = {25'd0, popCount(regList), 2'b00};
    // Transfers always run upward, so decrementing modes start at the bottom of the block.
    case ({up, pre})
      2'b10:   startAddr = base;
      2'b11:   startAddr = base + 32'd4;
      2'b00:   startAddr = base - xferBytes + 32'd4;
      default: startAddr = base - xferBytes;
    endcase
    wbCalc   = up ? base + xferBytes : base - xferBytes;
    maskNext = mask & (mask - 16'd1);
    nextAddr = ADDR + 32'd4;
    // A load that includes the base register keeps the loaded word instead of the writeback.
    skipWb   = !wbEn || (MEM_RW && regList[baseSel]);
  end

  always_ff @(posedge Clk or negedge RESET) begin
    if (!RESET) begin
      state   <= IDLE;
      regList <= 16'd0;
      mask    <= 16'd0;
      base    <= 32'd0;
      wbVal   <= 32'd0;
      up      <= 1'b0;
      pre     <= 1'b0;
      wbEn    <= 1'b0;
      baseSel <= 4'd0;
      MEM_REQ <= 1'b0;
      MEM_RW  <= 1'b0;
      ADDR    <= 32'd0;
      REG_SEL <= 4'd0;
      RF_LOAD <= 1'b0;
      RF_DATA <= 32'd0;
      BUSY    <= 1'b0;
      DONE    <= 1'b0;
    end else begin
      RF_LOAD <= 1'b0;
      DONE    <= 1'b0;
      case (state)
        IDLE: begin
          if (START) begin
            regList <= REGLIST;
            base    <= BASE;
            up      <= UP;
            pre     <= PRE;
            MEM_RW  <= LDOP;
            wbEn    <= WBEN;
            baseSel <= BASE_SEL;
            BUSY    <= 1'b1;
            state   <= SETUP;
          end
        end
        SETUP: begin
          wbVal <= wbCalc;
          if (regList == 16'd0) begin
            DONE  <= 1'b1;
            state <= FIN;
          end else begin
            mask    <= regList;
            ADDR    <= startAddr;
            REG_SEL <= lowestSet(regList);
            MEM_REQ <= 1'b1;
            state   <= REQ;
          end
        end
        REQ: begin
          if (MEM_REQ && MEM_DONE) begin
            mask <= maskNext;
            ADDR <= nextAddr;
            if (MEM_RW) begin
              MEM_REQ <= 1'b0;
              RF_LOAD <= 1'b1;
              RF_DATA <= MEM_RDATA;
              state   <= WRITE;
            end else if (maskNext != 16'd0) begin
              REG_SEL <= lowestSet(maskNext);
            end else begin
              MEM_REQ <= 1'b0;
              if (skipWb) begin
                DONE  <= 1'b1;
                state <= FIN;
              end else begin
                RF_LOAD <= 1'b1;
                REG_SEL <= baseSel;
                RF_DATA <= wbVal;
                state   <= WBACK;
              end
            end
          end
        end
        WRITE: begin
          if (mask != 16'd0) begin
            REG_SEL <= lowestSet(mask);
            MEM_REQ <= 1'b1;
            state   <= REQ;
          end else if (skipWb) begin
            DONE  <= 1'b1;
            state <= FIN;
          end else begin
            RF_LOAD <= 1'b1;
            REG_SEL <= baseSel;
            RF_DATA <= wbVal;
            state   <= WBACK;
          end
        end
        WBACK: begin
          DONE  <= 1'b1;
          state <= FIN;
        end
        FIN: begin
          BUSY  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
